// File: rtl/uart_baudgen_frac.sv
// Fractional-divisor UART bit-timing generator: TX strobes at bit ends, RX strobes at bit centres.
// Strobes are combinational from registered counters; no backpressure, divisor changes land only at period starts.
module uart_baudgen_chan #(
    parameter int DIV_W          = 16,
    parameter int FRAC_W         = 4,
    parameter int RESET_DIV_INT  = 868,
    parameter int RESET_DIV_FRAC = 1,
    parameter bit CENTRE         = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    input  logic              load,
    input  logic [DIV_W-1:0]  shadow_int,
    input  logic [FRAC_W-1:0] shadow_frac,
    output logic              strb,
    output logic              upd
);
    localparam logic [DIV_W:0] ONE_X = {{DIV_W{1'b0}}, 1'b1};

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_int;
    logic [DIV_W-1:0]  eff_int;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] div_frac;
    logic [FRAC_W-1:0] eff_frac;
    logic [DIV_W:0]    period;
    logic [DIV_W:0]    cnt_x;
    logic [FRAC_W:0]   acc_sum;
    logic              running;
    logic              active;
    logic              wrap;
    logic              pstart;
    logic              apply;

    // The first enabled cycle counts as cycle 0 of the first period; its period is
    // computed at the end of that cycle, so compares are gated by running.
    always_comb begin
        active   = en && !restart;
        cnt_x    = {1'b0, cnt};
        wrap     = running && (cnt_x == period - ONE_X);
        pstart   = active && (!running || wrap);
        apply    = upd && (!active || pstart);
        eff_int  = apply ? shadow_int : div_int;
        eff_frac = apply ? shadow_frac : div_frac;
        acc_sum  = {1'b0, acc} + {1'b0, eff_frac};
        if (CENTRE) begin
            strb = active && running && (cnt_x == (period >> 1));
        end else begin
            strb = active && wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            period   <= '0;
            running  <= 1'b0;
            upd      <= 1'b0;
            div_int  <= DIV_W'(RESET_DIV_INT);
            div_frac <= FRAC_W'(RESET_DIV_FRAC);
        end else begin
            running <= active;
            // A load coinciding with an apply wins, so the newest shadow is picked up next time.
            if (load) begin
                upd <= 1'b1;
            end else if (apply) begin
                upd <= 1'b0;
            end
            if (apply) begin
                div_int  <= shadow_int;
                div_frac <= shadow_frac;
            end
            if (!active) begin
                cnt <= '0;
                acc <= '0;
            end else if (pstart) begin
                cnt    <= running ? {DIV_W{1'b0}} : {{(DIV_W-1){1'b0}}, 1'b1};
                acc    <= acc_sum[FRAC_W-1:0];
                period <= {1'b0, eff_int} + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
            end else begin
                cnt <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end
endmodule

module uart_baudgen_frac #(
    parameter int DIV_W          = 16,
    parameter int FRAC_W         = 4,
    parameter int RESET_DIV_INT  = 868,
    parameter int RESET_DIV_FRAC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  i_div_int,
    input  logic [FRAC_W-1:0] i_div_frac,
    input  logic              i_div_load,
    input  logic              i_tx_en,
    input  logic              i_tx_restart,
    input  logic              i_rx_en,
    input  logic              i_rx_restart,
    output logic              o_tx_strb,
    output logic              o_rx_strb,
    output logic              o_cfg_err,
    output logic              o_update_pending
);
    logic [DIV_W-1:0]  shadow_int;
    logic [FRAC_W-1:0] shadow_frac;
    logic              tx_upd;
    logic              rx_upd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_int  <= DIV_W'(RESET_DIV_INT);
            shadow_frac <= FRAC_W'(RESET_DIV_FRAC);
            o_cfg_err   <= 1'b0;
        end else if (i_div_load) begin
            shadow_frac <= i_div_frac;
            // Divisors below 2 cannot place a centre strobe inside the bit; clamp and flag.
            if (i_div_int < DIV_W'(2)) begin
                shadow_int <= DIV_W'(2);
                o_cfg_err  <= 1'b1;
            end else begin
                shadow_int <= i_div_int;
            end
        end
    end

    uart_baudgen_chan #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .RESET_DIV_INT(RESET_DIV_INT),
        .RESET_DIV_FRAC(RESET_DIV_FRAC), .CENTRE(1'b0)
    ) u_tx (
        .clk(clk), .rst_n(rst_n), .en(i_tx_en), .restart(i_tx_restart), .load(i_div_load),
        .shadow_int(shadow_int), .shadow_frac(shadow_frac), .strb(o_tx_strb), .upd(tx_upd)
    );

    uart_baudgen_chan #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .RESET_DIV_INT(RESET_DIV_INT),
        .RESET_DIV_FRAC(RESET_DIV_FRAC), .CENTRE(1'b1)
    ) u_rx (
        .clk(clk), .rst_n(rst_n), .en(i_rx_en), .restart(i_rx_restart), .load(i_div_load),
        .shadow_int(shadow_int), .shadow_frac(shadow_frac), .strb(o_rx_strb), .upd(rx_upd)
    );

    assign o_update_pending = tx_upd | rx_upd;
endmodule

// File: doc/uart_baudgen_frac.md
Name: uart_baudgen_frac

Overview:
Next-generation UART bit-timing generator with a runtime-programmable fractional divisor, replacing fixed baud-rate tables. It provides two independent channels from one shared configuration: TX strobes at bit ends, and RX strobes at bit centres with restart on start-bit detection. It sits between the CSR block, which supplies the divisor, and the UART TX/RX shifters, which consume the strobes. Divisor changes are applied glitch-free at bit boundaries.

Parameters:
DIV_W, 16, width of integer divisor (clock cycles per bit).
FRAC_W, 4, width of fractional divisor; resolution 1/2^FRAC_W cycle.
RESET_DIV_INT, 868, integer divisor after reset (100 MHz / 115200).
RESET_DIV_FRAC, 1, fractional divisor after reset.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_div_int  in  DIV_W  requested integer divisor
i_div_frac  in  FRAC_W  requested fractional divisor
i_div_load  in  1  one-cycle pulse; capture i_div_int/i_div_frac into shadow
i_tx_en  in  1  TX channel enable
i_tx_restart  in  1  restart TX bit timing (frame start)
i_rx_en  in  1  RX channel enable
i_rx_restart  in  1  restart RX bit timing (start-bit falling edge seen)
o_tx_strb  out  1  one-cycle pulse at last cycle of each TX bit period
o_rx_strb  out  1  one-cycle pulse at centre of each RX bit period
o_cfg_err  out  1  sticky; last loaded i_div_int < 2 (clamped)
o_update_pending  out  1  shadow divisor not yet applied to both channels

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - shadow and both active divisors = RESET_DIV_INT/RESET_DIV_FRAC.
  - Counters and fractional accumulators = 0.
  - All outputs = 0.
- Shadow load: i_div_load=1 captures inputs next cycle.
  - If i_div_int < 2, store 2 and set o_cfg_err (held until reset).
  - A later load overwrites the shadow; only the newest shadow value is applied.
- Per-channel state (TX and RX identical except strobe position):
  - cnt[DIV_W], acc[FRAC_W], period[DIV_W+1], active div_int/div_frac, upd flag.
- Period start (cnt wraps to 0, or channel enable/restart):
  - {carry, acc} = acc + div_frac; period = div_int + carry.
  - Period start uses the active divisor as it stands after any update in the same cycle.
  - Example: div_frac=8, FRAC_W=4 gives periods 4,5,4,5... for div_int=4; average 4.5.
- Counting (enabled, no restart): cnt increments each cycle; at cnt==period-1, cnt -> 0 and a new period starts.
- Strobes are combinational from registered state, asserted only when the channel is enabled and its restart is low.
  - o_tx_strb when tx cnt == period-1.
  - o_rx_strb when rx cnt == period>>1.
- First TX strobe comes `period` cycles after enable rises or restart deasserts. First RX strobe comes (period>>1)+1 cycles after.
- Enable low: cnt=0, acc=0, no strobes; channel is idle.
- Restart high: cnt=0, acc=0, no strobe that cycle; counting starts the next cycle. Restart has priority over wrap and over enable-rise.
- Divisor update:
  - On shadow capture, both channels' upd flags set.
  - Each channel copies shadow to its active divisor at its next period start, wrap, restart, or while disabled, then clears upd.
  - The new value never alters a period in progress.
  - o_update_pending = tx upd | rx upd.
  - A load in the same cycle as a period start is applied at the following period start.
- Width rules:
  - period is computed at DIV_W+1 bits; div_int = 2^DIV_W-1 with carry must not overflow.
  - cnt compare is at DIV_W+1 bits.
- Reset mid-operation: immediate return to reset values; any pending update is discarded.

Test Plan:
- Load div_int=4, frac=0, i_tx_en=1 -> o_tx_strb every 4 cycles, first strobe 4 cycles after enable; o_update_pending clears at first period start.
- Load div_int=4, frac=8 -> TX strobe spacing 4,5,4,5; RX strobes at cnt 2 in each period; 32 strobes span 144 cycles.
- RX enabled with div_int=10, frac=0; pulse i_rx_restart mid-period -> no strobe that cycle, next o_rx_strb 6 cycles after restart deasserts, then every 10 cycles.
- While TX is counting with div_int=8, load div_int=6 -> current period stays 8, following periods 6; simultaneous load and wrap -> applied one period later.
- Load div_int=1 -> stored as 2, o_cfg_err=1 and stays set after a valid load; strobes every 2 cycles.
- Assert rst_n=0 mid-period with a pending update -> all outputs 0; after release and enable, period = 868 + carry per RESET_DIV_FRAC=1 (one 869-cycle period per 16).
